reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, data width of every register and data port.
REQ-002 The block SHALL take parameter DEPTH, default 8, number of registers (power of two, min 2); AW = $clog2(DEPTH).
REQ-003 The block SHALL take parameter BYPASS, default 0: 1 = same-cycle write data forwarded to reads, 0 = old data returned.
REQ-004 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port rw  input  1  1 = write cycle, 0 = read-only cycle.
REQ-007 The block SHALL have port ldm  input  1  write source select: load bus.
REQ-008 The block SHALL have port lacc  input  1  write source select: accumulator.
REQ-009 The block SHALL have port lsc  input  1  write source select: shift-left-in-place of addressed register.
REQ-010 The block SHALL have port waddr  input  AW  write address.
REQ-011 The block SHALL have ports raddr_a, raddr_b  input  AW  read addresses, ports A and B.
REQ-012 The block SHALL have ports load, acc  input  WIDTH  write data sources.
REQ-013 The block SHALL have port clr_dirty  input  1  clears all dirty bits.
REQ-014 The block SHALL have ports out_a, out_b  output  WIDTH  registered read data.
REQ-015 The block SHALL have port out_valid  output  1  out_a/out_b hold data for a read-only cycle.
REQ-016 The block SHALL have port dirty_cnt  output  AW+1  number of registers written since last clear.
REQ-017 The block SHALL have port err  output  1  one-cycle pulse on illegal select combination.

Function
REQ-018 A write SHALL commit on the rising clk edge when rw=1 and exactly one of ldm/lacc/lsc is 1.
REQ-019 ldm SHALL store load; lacc SHALL store acc; lsc SHALL store reg[waddr] shifted left one bit, LSB 0, MSB discarded.
REQ-020 rw=1 with zero selects SHALL leave all registers unchanged, no err.
REQ-021 rw=1 with two or more selects SHALL write nothing and SHALL assert err for exactly the following cycle.
REQ-022 out_a/out_b SHALL update every cycle to reg[raddr_a]/reg[raddr_b]: one-cycle latency, no combinational path from inputs.
REQ-023 out_valid SHALL be 1 in the cycle after a cycle with rw=0, else 0.
REQ-024 Read address equal to committing waddr: BYPASS=0 returns pre-write value, BYPASS=1 returns written value (including shifted value).
REQ-025 A committed write SHALL set dirty[waddr]; clr_dirty SHALL clear all dirty bits at the edge.
REQ-026 Simultaneous clr_dirty and committed write: all bits clear except dirty[waddr], which ends 1.
REQ-027 dirty_cnt SHALL equal the popcount of dirty bits after each edge (range 0..DEPTH, no wrap).
REQ-028 Rewriting an already-dirty register SHALL not change dirty_cnt.

Reset
REQ-029 rst=0 SHALL immediately, without clk, clear all registers, dirty bits, out_a, out_b, out_valid, dirty_cnt and err to 0.
REQ-030 A write in progress when rst falls SHALL be discarded; first write SHALL be possible on the first rising edge after rst rises.

Structure
REQ-031 Source-select encoding and WIDTH/DEPTH defaults SHALL live in the shared project package with the other CPU constants.
REQ-032 The dirty bit vector and popcount SHALL be one sub-module, dirty_tracker, parametrised by DEPTH.

Verification
REQ-033 Reset: rst=0 for 10 ns mid-cycle -> all outputs 0 before next clk edge.
REQ-034 Write sources: waddr=3 lacc=1 acc=0x0008, then waddr=5 ldm=1 load=0x0006, then read 3/5 -> out_a=0x0008, out_b=0x0006, out_valid=1 one cycle later, dirty_cnt=2.
REQ-035 Shift: reg[2]=0x8001, rw=1 lsc=1 waddr=2, then read -> 0x0002.
REQ-036 Illegal: rw=1 ldm=1 lacc=1 waddr=1 -> reg[1] unchanged, err high one cycle, dirty_cnt unchanged.
REQ-037 Collision: write 0x00AA to reg 4 while raddr_a=4 -> out_a next cycle = old value (BYPASS=0) or 0x00AA (BYPASS=1).
REQ-038 Dirty: write all DEPTH registers -> dirty_cnt=DEPTH; clr_dirty with write to reg 0 -> dirty_cnt=1.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared CPU constants: register-file geometry defaults and write-source select encoding.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package reg_file_mp_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Decoded write source; SEL_ILLEGAL covers any case with more than one select bit set.
  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_LOAD    = 3'd1,
    SEL_ACC     = 3'd2,
    SEL_SHIFT   = 3'd3,
    SEL_ILLEGAL = 3'd4
  } sel_t;

  function automatic sel_t decode_sel(input logic ldm, input logic lacc, input logic lsc);
    sel_t s;
    case ({ldm, lacc, lsc})
      3'b000:  s = SEL_NONE;
      3'b100:  s = SEL_LOAD;
      3'b010:  s = SEL_ACC;
      3'b001:  s = SEL_SHIFT;
      default: s = SEL_ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bundle of register-file control, data and status signals between a driver and the register file.
// Latency: n/a (wires only).
// Backpressure: none; every cycle is accepted.
interface reg_file_mp_if
  import reg_file_mp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             rw;
  logic             ldm;
  logic             lacc;
  logic             lsc;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] acc;
  logic             clr_dirty;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             out_valid;
  logic [AW:0]      dirty_cnt;
  logic             err;

  modport master (
    output rw, ldm, lacc, lsc, waddr, raddr_a, raddr_b, load, acc, clr_dirty,
    input  out_a, out_b, out_valid, dirty_cnt, err
  );

  modport slave (
    input  rw, ldm, lacc, lsc, waddr, raddr_a, raddr_b, load, acc, clr_dirty,
    output out_a, out_b, out_valid, dirty_cnt, err
  );

endinterface

// File: rtl/reg_file_mp_dirty_tracker.sv
// Per-register dirty bits with a population count of the set bits.
// Latency: bits update at the clock edge; cnt follows the stored bits with no extra cycle.
// Backpressure: none.
module dirty_tracker #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr,
  output logic [AW:0]   cnt
);

  logic [DEPTH-1:0] dirty;
  logic [DEPTH-1:0] dirty_nxt;

  // Clear first, then set, so a write in the clearing cycle leaves its own bit marked.
  always_comb begin
    dirty_nxt = clr ? '0 : dirty;
    if (set_en) dirty_nxt[set_idx] = 1'b1;
  end

  // Dirty bit storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dirty <= '0;
    else      dirty <= dirty_nxt;
  end

  // Popcount of the stored bits; AW+1 bits hold DEPTH without wrap.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + (AW+1)'(dirty[i]);
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-source register file: one write (load/acc/shift-in-place) and two registered reads per cycle.
// Latency: writes commit at the edge; out_a/out_b/out_valid/err appear one cycle after their inputs.
// Backpressure: none; illegal select combinations are dropped and flagged on err.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter bit BYPASS = 1'b0
) (
  input logic         clk,
  input logic         rst,
  reg_file_mp_if.slave bus
);

  logic [WIDTH-1:0] regs [DEPTH];
  sel_t             sel;
  logic             commit;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // Decode the write source and pick the data a committing write would store.
  always_comb begin
    sel    = decode_sel(bus.ldm, bus.lacc, bus.lsc);
    commit = bus.rw && (sel == SEL_LOAD || sel == SEL_ACC || sel == SEL_SHIFT);
    wdata  = regs[bus.waddr];
    case (sel)
      SEL_LOAD:  wdata = bus.load;
      SEL_ACC:   wdata = bus.acc;
      SEL_SHIFT: wdata = {regs[bus.waddr][WIDTH-2:0], 1'b0};
      default:   wdata = regs[bus.waddr];
    endcase
  end

  // Read muxes; with BYPASS a same-cycle write to the read address is forwarded.
  always_comb begin
    rd_a = regs[bus.raddr_a];
    rd_b = regs[bus.raddr_b];
    if (BYPASS && commit && bus.raddr_a == bus.waddr) rd_a = wdata;
    if (BYPASS && commit && bus.raddr_b == bus.waddr) rd_b = wdata;
  end

  // Register array; only a single-source write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[bus.waddr] <= wdata;
    end
  end

  // Registered read data, read-cycle marker and illegal-select pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_a     <= '0;
      bus.out_b     <= '0;
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.out_a     <= rd_a;
      bus.out_b     <= rd_b;
      bus.out_valid <= ~bus.rw;
      bus.err       <= bus.rw && (sel == SEL_ILLEGAL);
    end
  end

  dirty_tracker #(.DEPTH(DEPTH)) u_dirty (
    .clk     (clk),
    .rst     (rst),
    .set_en  (commit),
    .set_idx (bus.waddr),
    .clr     (bus.clr_dirty),
    .cnt     (bus.dirty_cnt)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one instance without and one with write-to-read bypass.
// Both instances see identical stimulus; expected values are hand-computed constants.
// Outputs are sampled 1 ns after the rising edge.
module tb_reg_file_mp;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_file_mp_if #(.WIDTH(16), .DEPTH(8)) b0 ();
  reg_file_mp_if #(.WIDTH(16), .DEPTH(8)) b1 ();

  assign b1.rw        = b0.rw;
  assign b1.ldm       = b0.ldm;
  assign b1.lacc      = b0.lacc;
  assign b1.lsc       = b0.lsc;
  assign b1.waddr     = b0.waddr;
  assign b1.raddr_a   = b0.raddr_a;
  assign b1.raddr_b   = b0.raddr_b;
  assign b1.load      = b0.load;
  assign b1.acc       = b0.acc;
  assign b1.clr_dirty = b0.clr_dirty;

  reg_file_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  reg_file_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.rw = 1'b0; b0.ldm = 1'b0; b0.lacc = 1'b0; b0.lsc = 1'b0; b0.clr_dirty = 1'b0;
  endtask

  task automatic wr(input int sel, input logic [2:0] a, input logic [15:0] d);
    idle();
    b0.rw = 1'b1; b0.waddr = a;
    b0.load = d; b0.acc = d;
    if (sel == 0) b0.ldm = 1'b1;
    else if (sel == 1) b0.lacc = 1'b1;
    else b0.lsc = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    idle();
    b0.raddr_a = a; b0.raddr_b = b;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    idle();
    b0.waddr = '0; b0.raddr_a = '0; b0.raddr_b = '0; b0.load = '0; b0.acc = '0;
    #3;
    chk("rst_out_a",     b0.out_a, 0);
    chk("rst_out_b",     b0.out_b, 0);
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_dirty_cnt", b0.dirty_cnt, 0);
    chk("rst_err",       b0.err, 0);
    #5 rst = 1'b1;

    // Write sources: acc into reg 3, load into reg 5, then read both.
    wr(1, 3'd3, 16'h0008); tick();
    chk("acc_wr_valid", b0.out_valid, 0);
    chk("acc_wr_dirty", b0.dirty_cnt, 1);
    wr(0, 3'd5, 16'h0006); tick();
    chk("ld_wr_dirty", b0.dirty_cnt, 2);
    rd(3'd3, 3'd5); tick();
    chk("src_out_a",  b0.out_a, 16'h0008);
    chk("src_out_b",  b0.out_b, 16'h0006);
    chk("src_valid",  b0.out_valid, 1);
    chk("src_dirty",  b0.dirty_cnt, 2);
    chk("src_b1_out_a", b1.out_a, 16'h0008);

    // Shift in place, read during the shift to exercise bypass of the shifted value.
    wr(0, 3'd2, 16'h8001); tick();
    wr(2, 3'd2, 16'h0000); b0.raddr_a = 3'd2; tick();
    chk("shift_col_nobyp", b0.out_a, 16'h8001);
    chk("shift_col_byp",   b1.out_a, 16'h0002);
    rd(3'd2, 3'd2); tick();
    chk("shift_out_a", b0.out_a, 16'h0002);
    chk("shift_dirty", b0.dirty_cnt, 3);

    // Illegal select: nothing written, one-cycle err.
    wr(0, 3'd1, 16'h1111); tick();
    chk("pre_ill_dirty", b0.dirty_cnt, 4);
    idle(); b0.rw = 1'b1; b0.ldm = 1'b1; b0.lacc = 1'b1; b0.waddr = 3'd1;
    b0.load = 16'h2222; b0.acc = 16'h3333; b0.raddr_a = 3'd1; tick();
    chk("ill_err",      b0.err, 1);
    chk("ill_out_a",    b0.out_a, 16'h1111);
    chk("ill_b1_out_a", b1.out_a, 16'h1111);
    chk("ill_dirty",    b0.dirty_cnt, 4);
    rd(3'd1, 3'd0); tick();
    chk("ill_err_drop", b0.err, 0);
    chk("ill_reg1",     b0.out_a, 16'h1111);

    // rw with no select: no write, no err.
    idle(); b0.rw = 1'b1; b0.waddr = 3'd6; b0.load = 16'h7777; tick();
    chk("nosel_err",   b0.err, 0);
    chk("nosel_dirty", b0.dirty_cnt, 4);
    rd(3'd0, 3'd6); tick();
    chk("nosel_reg6", b0.out_b, 16'h0000);

    // Read/write collision on reg 4.
    wr(0, 3'd4, 16'h0055); tick();
    wr(0, 3'd4, 16'h00AA); b0.raddr_a = 3'd4; tick();
    chk("col_nobyp", b0.out_a, 16'h0055);
    chk("col_byp",   b1.out_a, 16'h00AA);
    chk("col_valid", b0.out_valid, 0);
    rd(3'd4, 3'd4); tick();
    chk("col_after", b0.out_a, 16'h00AA);
    chk("col_dirty", b0.dirty_cnt, 5);

    // Dirty saturation at DEPTH, then clear combined with a write.
    for (int i = 0; i < 8; i++) begin
      wr(1, 3'(i), 16'(i)); tick();
    end
    chk("dirty_full", b0.dirty_cnt, 8);
    wr(0, 3'd0, 16'h0F0F); b0.clr_dirty = 1'b1; tick();
    chk("dirty_clr_wr", b0.dirty_cnt, 1);
    wr(0, 3'd0, 16'h0F0F); tick();
    chk("dirty_rewrite", b0.dirty_cnt, 1);
    idle(); b0.clr_dirty = 1'b1; tick();
    chk("dirty_clr", b0.dirty_cnt, 0);

    // Asynchronous reset mid-cycle with a write pending.
    wr(1, 3'd7, 16'h0077); tick();
    rd(3'd4, 3'd3); tick();
    chk("pre_rst_a",     b0.out_a, 16'h0004);
    chk("pre_rst_b",     b0.out_b, 16'h0003);
    chk("pre_rst_dirty", b0.dirty_cnt, 1);
    wr(0, 3'd4, 16'hBEEF);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_a",     b0.out_a, 0);
    chk("arst_out_b",     b0.out_b, 0);
    chk("arst_out_valid", b0.out_valid, 0);
    chk("arst_dirty",     b0.dirty_cnt, 0);
    chk("arst_err",       b0.err, 0);
    #9 rst = 1'b1;
    tick();
    chk("post_rst_dirty", b0.dirty_cnt, 1);
    rd(3'd4, 3'd3); tick();
    chk("post_rst_a", b0.out_a, 16'hBEEF);
    chk("post_rst_b", b0.out_b, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
